// File: rtl/led_panel_pkg.sv
// Shared constants and FSM encoding for the led_panel_4k frame path.
package led_panel_pkg;

  localparam int unsigned PANEL_W      = 64;
  localparam int unsigned PANEL_H      = 32;
  localparam int unsigned PIX_BITS     = 12;
  localparam int unsigned PIX_IDX_BITS = 11;
  localparam int unsigned ADDR_BITS    = 12;

  typedef enum logic [2:0] {
    StIdle,
    StB0,
    StB1,
    StB2,
    StSwapWait
  } state_e;

endpackage

// File: rtl/led_frame_loader_if.sv
// Byte-stream handshake plus frame-memory write port of the frame loader.
interface led_frame_loader_if
  import led_panel_pkg::*;
();

  logic [7:0]           s_data;
  logic                 s_valid;
  logic                 s_sof;
  logic                 s_ready;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [PIX_BITS-1:0]  wr_data;

  // Stream source / memory sink side
  modport master (
    output s_data, s_valid, s_sof,
    input  s_ready, wr_en, wr_addr, wr_data
  );

  // Frame loader side
  modport slave (
    input  s_data, s_valid, s_sof,
    output s_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/pix12_unpack.sv
// Unpacks two 12-bit pixels from three stream bytes. pix/pix_valid are
// combinational on the byte that completes a pixel; the caller registers them.
module pix12_unpack
  import led_panel_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          data,
  input  logic                load0,
  input  logic                load1,
  input  logic                load2,
  output logic [PIX_BITS-1:0] pix,
  output logic                pix_valid
);

  logic [7:0] b0_q;  // p0[11:4]
  logic [3:0] p1_hi_q;  // p1[11:8]

  // Capture the bytes that only carry part of a pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      b0_q    <= '0;
      p1_hi_q <= '0;
    end else begin
      if (load0) b0_q <= data;
      if (load1) p1_hi_q <= data[3:0];
    end
  end

  // Select the pixel completed by the current byte
  always_comb begin
    pix       = load1 ? {b0_q, data[7:4]} : {p1_hi_q, data};
    pix_valid = load1 | load2;
  end

endmodule

// File: rtl/led_frame_loader.sv
// Stream-to-frame-memory loader for the 64x32 12 bpp panel.
// Define LED_DOUBLE_BUFFER_EN for two banks with a swap on the display's
// frame_end_in; otherwise a single bank is written directly.
module led_frame_loader
  import led_panel_pkg::*;
#(
  parameter int unsigned WIDTH  = PANEL_W,
  parameter int unsigned HEIGHT = PANEL_H,
  parameter int unsigned BPP    = PIX_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  led_frame_loader_if.slave    bus,
  output logic                 rd_bank,
  input  logic                 frame_end_in,
  output logic                 frame_done,
  output logic                 err_sof
);

  // Pixel index of p0 in the final pair of a frame
  localparam logic [PIX_IDX_BITS-1:0] LastIdx = PIX_IDX_BITS'(WIDTH * HEIGHT - 2);

  state_e                  state_q, state_d;
  logic [PIX_IDX_BITS-1:0] n_q, n_d;
  logic [PIX_IDX_BITS-1:0] wr_idx;
  logic                    accept, load0, load1, load2, sof_err, last, swap;
  logic [BPP-1:0]          pix;
  logic                    pix_valid, wr_bank;
  logic                    ready_q, wr_en_q, frame_done_q, err_sof_q;
  logic [ADDR_BITS-1:0]    wr_addr_q;
  logic [BPP-1:0]          wr_data_q;

  assign accept = bus.s_valid & bus.s_ready;

  // State and pixel counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
    end
  end

  // Next state: a SOF byte always restarts at pixel 0 from any byte phase
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    unique case (state_q)
      StIdle: if (accept && bus.s_sof) state_d = StB1;
      StB0: begin
        if (accept) begin
          state_d = StB1;
          if (bus.s_sof) n_d = '0;
        end
      end
      StB1: begin
        if (accept) begin
          if (bus.s_sof) n_d = '0;
          else state_d = StB2;
        end
      end
      StB2: begin
        if (accept) begin
          if (bus.s_sof) begin
            n_d     = '0;
            state_d = StB1;
          end else if (n_q == LastIdx) begin
            n_d = '0;
`ifdef LED_DOUBLE_BUFFER_EN
            state_d = StSwapWait;
`else
            state_d = StIdle;
`endif
          end else begin
            n_d     = n_q + PIX_IDX_BITS'(2);
            state_d = StB0;
          end
        end
      end
`ifdef LED_DOUBLE_BUFFER_EN
      StSwapWait: if (frame_end_in) state_d = StIdle;
`else
      StSwapWait: state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

  // Output decode: byte-phase strobes, error and last-pixel flags
  always_comb begin
    load0   = 1'b0;
    load1   = 1'b0;
    load2   = 1'b0;
    sof_err = 1'b0;
    last    = 1'b0;
    wr_idx  = n_q;
    if (accept) begin
      unique case (state_q)
        StIdle: load0 = bus.s_sof;
        StB0: begin
          load0   = 1'b1;
          sof_err = bus.s_sof && (n_q != '0);
        end
        StB1: begin
          load0   = bus.s_sof;
          load1   = !bus.s_sof;
          sof_err = bus.s_sof;
        end
        StB2: begin
          load0   = bus.s_sof;
          load2   = !bus.s_sof;
          sof_err = bus.s_sof;
          last    = !bus.s_sof && (n_q == LastIdx);
          wr_idx  = n_q + PIX_IDX_BITS'(1);
        end
        default: ;
      endcase
    end
  end

  pix12_unpack u_unpack (
    .clk       (clk),
    .rst       (rst),
    .data      (bus.s_data),
    .load0     (load0),
    .load1     (load1),
    .load2     (load2),
    .pix       (pix),
    .pix_valid (pix_valid)
  );

`ifdef LED_DOUBLE_BUFFER_EN
  logic rd_bank_q;

  assign swap = (state_q == StSwapWait) && frame_end_in;

  // Display bank flips only once the display has finished its scan
  always_ff @(posedge clk) begin
    if (rst) rd_bank_q <= 1'b0;
    else if (swap) rd_bank_q <= ~rd_bank_q;
  end

  assign rd_bank = rd_bank_q;
  assign wr_bank = ~rd_bank_q;
`else
  logic unused_frame_end;

  assign unused_frame_end = frame_end_in;
  assign swap    = 1'b0;
  assign rd_bank = 1'b0;
  assign wr_bank = 1'b0;
`endif

  // Registered write port and status pulses; address/data hold between writes
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      err_sof_q    <= 1'b0;
    end else begin
      ready_q      <= (state_d != StSwapWait);
      wr_en_q      <= pix_valid;
      frame_done_q <= last;
      err_sof_q    <= sof_err;
      if (pix_valid) begin
        wr_addr_q <= {wr_bank, wr_idx};
        wr_data_q <= pix;
      end
    end
  end

  assign bus.s_ready = ready_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign frame_done  = frame_done_q;
  assign err_sof     = err_sof_q;

endmodule
